// File: rtl/regfile.sv
// 32 x 32-bit register file, two combinational read ports, one write port, r0 hard-wired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        re1,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic        re2,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2
);

    logic [31:0] mem_q [32];
    logic [31:0] mem_d [32];
    logic        wr_en;

    assign wr_en = we && (waddr != 5'd0) && !rst;

    // Reset wins over a concurrent write; entry 0 is never written so it stays zero after reset.
    always_comb begin
        mem_d = mem_q;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem_d[i] = 32'h0;
            end
        end else if (wr_en) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    function automatic logic [31:0] read_port(input logic re, input logic [4:0] raddr);
        logic [31:0] value;
        if (rst || !re || (raddr == 5'd0)) begin
            value = 32'h0;
`ifdef REGFILE_BYPASS_EN
        end else if (wr_en && (raddr == waddr)) begin
            value = wdata;
`endif
        end else begin
            value = mem_q[raddr];
        end
        return value;
    endfunction

    assign rdata1 = read_port(re1, raddr1);
    assign rdata2 = read_port(re2, raddr2);

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  waddr = 5'd0;
   logic [31:0] wdata = 32'h0;
   logic        re1 = 1'b0;
   logic [4:0]  raddr1 = 5'd0;
   logic [31:0] rdata1;
   logic        re2 = 1'b0;
   logic [4:0]  raddr2 = 5'd0;
   logic [31:0] rdata2;

   int checkCount = 0;
   int passCount = 0;

   regfile dut (
      .clk(clk),
      .rst(rst),
      .we(we),
      .waddr(waddr),
      .wdata(wdata),
      .re1(re1),
      .raddr1(raddr1),
      .rdata1(rdata1),
      .re2(re2),
      .raddr2(raddr2),
      .rdata2(rdata2)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Advance past the next rising edge so inputs change and outputs settle away from it.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
      we = 1'b1;
      waddr = addr;
      wdata = data;
      applyStimulus();
      we = 1'b0;
   endtask

   logic [31:0] collisionExpect;

   initial begin
`ifdef REGFILE_BYPASS_EN
      collisionExpect = 32'h12345678;
`else
      collisionExpect = 32'h00000001;
`endif

      // Reset, reading during reset must already give zero.
      rst = 1'b1;
      re1 = 1'b1;
      re2 = 1'b1;
      raddr1 = 5'd5;
      raddr2 = 5'd31;
      applyStimulus();
      checkOutput("rst_rd1", rdata1, 32'h0);
      checkOutput("rst_rd2", rdata2, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 32; i++) begin
         raddr1 = 5'(i);
         raddr2 = 5'(31 - i);
         #1;
         checkOutput($sformatf("init_rd1_%0d", i), rdata1, 32'h0);
         checkOutput($sformatf("init_rd2_%0d", 31 - i), rdata2, 32'h0);
      end

      // Basic write then read, and read-enable gating.
      writeReg(5'd5, 32'hDEADBEEF);
      raddr1 = 5'd5;
      re1 = 1'b1;
      #1;
      checkOutput("r5_rd1", rdata1, 32'hDEADBEEF);
      re1 = 1'b0;
      #1;
      checkOutput("r5_re1_off", rdata1, 32'h0);
      re1 = 1'b1;

      // Writes to r0 are discarded.
      writeReg(5'd0, 32'hFFFFFFFF);
      raddr2 = 5'd0;
      re2 = 1'b1;
      #1;
      checkOutput("r0_rd2", rdata2, 32'h0);

      // Boundary index 31.
      writeReg(5'd31, 32'hCAFEF00D);
      raddr2 = 5'd31;
      #1;
      checkOutput("r31_rd2", rdata2, 32'hCAFEF00D);
      raddr1 = 5'd5;
      #1;
      checkOutput("r5_kept", rdata1, 32'hDEADBEEF);

      // Same-cycle write/read collision.
      writeReg(5'd7, 32'h00000001);
      we = 1'b1;
      waddr = 5'd7;
      wdata = 32'h12345678;
      raddr1 = 5'd7;
      raddr2 = 5'd5;
      #1;
      checkOutput("collide_rd1", rdata1, collisionExpect);
      checkOutput("collide_rd2_other", rdata2, 32'hDEADBEEF);
      applyStimulus();
      we = 1'b0;
      #1;
      checkOutput("collide_next", rdata1, 32'h12345678);

      // Reset mid-operation with a concurrent write.
      writeReg(5'd3, 32'hA5A5A5A5);
      raddr1 = 5'd3;
      #1;
      checkOutput("r3_before_rst", rdata1, 32'hA5A5A5A5);
      rst = 1'b1;
      we = 1'b1;
      waddr = 5'd4;
      wdata = 32'h00000055;
      raddr2 = 5'd3;
      #1;
      checkOutput("rst_comb_rd1", rdata1, 32'h0);
      checkOutput("rst_comb_rd2", rdata2, 32'h0);
      applyStimulus();
      rst = 1'b0;
      we = 1'b0;
      raddr1 = 5'd3;
      raddr2 = 5'd4;
      #1;
      checkOutput("r3_after_rst", rdata1, 32'h0);
      checkOutput("r4_after_rst", rdata2, 32'h0);
      raddr1 = 5'd5;
      raddr2 = 5'd31;
      #1;
      checkOutput("r5_after_rst", rdata1, 32'h0);
      checkOutput("r31_after_rst", rdata2, 32'h0);

      // Both ports reading the same index, while a non-colliding write is in flight.
      writeReg(5'd9, 32'h0000BEEF);
      raddr1 = 5'd9;
      raddr2 = 5'd9;
      we = 1'b1;
      waddr = 5'd10;
      wdata = 32'h77777777;
      #1;
      checkOutput("same_rd1", rdata1, 32'h0000BEEF);
      checkOutput("same_rd2", rdata2, 32'h0000BEEF);
      applyStimulus();
      we = 1'b0;
      raddr2 = 5'd10;
      #1;
      checkOutput("r10_rd2", rdata2, 32'h77777777);
      checkOutput("r9_kept", rdata1, 32'h0000BEEF);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
